// File: rtl/btn_pkg.sv
// Shared timing defaults for a 100 MHz core clock, plus board button index constants.
package btn_pkg;

    localparam int CLK_HZ              = 100_000_000;
    localparam int DEF_N_BTN           = 5;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int DEF_REPEAT_DELAY    = CLK_HZ / 2;    // 500 ms
    localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 10;   // 100 ms

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: synchroniser, debounce counter, press/release edge pulses, auto-repeat.
// Latency raw step -> level/press: SYNC_STAGES+DEBOUNCE_CYCLES clocks; no backpressure (pulses are fire-and-forget).
module btn_debounce_chan #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_btn_press,
    output logic o_btn_release,
    output logic o_btn_repeat
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_s;
    logic                   w_mismatch;
    logic                   w_commit;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_mismatch = (w_s != r_level);
    assign w_commit   = w_mismatch && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
            r_press   <= w_commit & w_s;
            r_release <= w_commit & ~w_s;
            // Any cycle where the synced input agrees with the level restarts the count.
            if (!w_mismatch || w_commit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_level <= w_s;
            end
        end
    end

    generate
        if (REPEAT_DELAY > 0) begin : g_rep
            localparam int H_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int H_W   = $clog2(H_MAX + 1);

            logic [H_W-1:0] r_hcnt;
            logic           r_periodic;
            logic           r_repeat;
            logic           w_hit;

            assign w_hit = (r_hcnt == (r_periodic ? H_W'(REPEAT_PERIOD - 1)
                                                  : H_W'(REPEAT_DELAY - 1)));

            // A commit while level is 1 is a release: suppress any repeat landing on it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hcnt     <= '0;
                    r_periodic <= 1'b0;
                    r_repeat   <= 1'b0;
                end else if (!r_level || w_commit) begin
                    r_hcnt     <= '0;
                    r_periodic <= 1'b0;
                    r_repeat   <= 1'b0;
                end else begin
                    r_repeat <= w_hit;
                    if (w_hit) begin
                        r_hcnt     <= '0;
                        r_periodic <= 1'b1;
                    end else begin
                        r_hcnt <= r_hcnt + H_W'(1);
                    end
                end
            end

            assign o_btn_repeat = r_repeat;
        end else begin : g_norep
            assign o_btn_repeat = 1'b0;
        end
    endgenerate

    assign o_btn_level   = r_level;
    assign o_btn_press   = r_press;
    assign o_btn_release = r_release;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Multi-channel button conditioner: N_BTN independent debounce/pulse channels, wiring only.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES clocks per channel; outputs are registered pulses, no backpressure.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_chan
            btn_debounce_chan #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_chan (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_btn_raw    (btn_raw[g]),
                .o_btn_level  (btn_level[g]),
                .o_btn_press  (btn_press[g]),
                .o_btn_release(btn_release[g]),
                .o_btn_repeat (btn_repeat[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse with 2 channels, 4-cycle debounce, repeat delay 10 / period 3.
module tb_btn_debounce_pulse;

    localparam int LAT     = 2 + 4;  // SYNC_STAGES + DEBOUNCE_CYCLES
    localparam int RDELAY  = 10;
    localparam int RPERIOD = 3;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_repeat;

    ev_t        q[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         k;
    logic [1:0] exp_level = 2'b00;
    logic [1:0] exp_p;
    logic [1:0] exp_r;
    logic [1:0] exp_t;

    btn_debounce_pulse #(
        .N_BTN          (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_PERIOD  (RPERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input int ch, input int kind);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        q.push_back(e);
    endtask

    // Press at p, release at r, auto-repeats strictly before the release.
    task automatic push_hold(input int ch, input int p, input int r);
        push_ev(p, ch, K_PRESS);
        for (int c = p + RDELAY; c < r; c += RPERIOD) push_ev(c, ch, K_REP);
        push_ev(r, ch, K_REL);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   btn_level,   2'b00);
        check({tag, "_press"},   btn_press,   2'b00);
        check({tag, "_release"}, btn_release, 2'b00);
        check({tag, "_repeat"},  btn_repeat,  2'b00);
    endtask

    // Scoreboard: events scheduled for this cycle are popped and compared every cycle.
    always @(posedge clk) begin
        #1;
        cyc   = cyc + 1;
        exp_p = 2'b00;
        exp_r = 2'b00;
        exp_t = 2'b00;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                case (q[i].kind)
                    K_PRESS: exp_p[q[i].ch] = 1'b1;
                    K_REL:   exp_r[q[i].ch] = 1'b1;
                    default: exp_t[q[i].ch] = 1'b1;
                endcase
                q.delete(i);
            end
        end
        if (!rst_n) exp_level = 2'b00;
        else        exp_level = (exp_level | exp_p) & ~exp_r;
        check("level",   btn_level,   exp_level);
        check("press",   btn_press,   exp_p);
        check("release", btn_release, exp_r);
        check("repeat",  btn_repeat,  exp_t);
    end

    initial begin
        // Button held through reset: fresh press LAT cycles after release of reset.
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        tick(4);
        rst_n = 1'b1;
        k     = cyc;
        push_hold(0, k + LAT, k + LAT + LAT);
        push_hold(1, k + LAT, k + LAT + LAT);
        tick(LAT);
        btn_raw = 2'b00;
        tick(12);

        // Bounce on ch0 (2-cycle toggles), then a clean hold of 30 cycles with repeats.
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = ~btn_raw[0];
            tick(2);
        end
        btn_raw[0] = 1'b1;
        k          = cyc;
        push_hold(0, k + LAT, k + LAT + 30 + LAT);
        tick(LAT + 30);
        btn_raw[0] = 1'b0;
        tick(12);

        // Glitch one cycle short of the debounce window.
        btn_raw[0] = 1'b1;
        tick(3);
        btn_raw[0] = 1'b0;
        tick(10);

        // Reset two cycles into a debounce.
        btn_raw[0] = 1'b1;
        tick(2);
        q.delete();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_debounce");
        tick(3);
        rst_n = 1'b1;
        k     = cyc;
        push_ev(k + LAT, 0, K_PRESS);
        push_ev(k + LAT + RDELAY, 0, K_REP);
        tick(LAT + 12);
        // Reset mid-hold, after the first repeat: level must drop at once.
        q.delete();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_hold");
        tick(3);
        rst_n = 1'b1;
        k     = cyc;
        push_hold(0, k + LAT, k + LAT + LAT);
        tick(LAT);
        btn_raw[0] = 1'b0;
        tick(10);

        // Both pressed together, released 5 cycles apart.
        btn_raw = 2'b11;
        k       = cyc;
        push_hold(0, k + LAT, k + LAT + 21);
        push_hold(1, k + LAT, k + LAT + 26);
        tick(21);
        btn_raw[0] = 1'b0;
        tick(5);
        btn_raw[1] = 1'b0;
        tick(12);

        tick(3);
        n_checks++;
        assert (q.size() == 0)
        else begin
            n_errors++;
            $error("FAIL pending_events observed=%0d expected=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
